// File: rtl/strobe_seq_rx.sv
// Strobe-qualified counter sample receiver: sequence checker (previous + STEP, mod 2^W)
// feeding a show-ahead FIFO drained over valid/ready, with error counting and overflow flag.
module strobe_seq_rx #(
  parameter int W     = 16,
  parameter int STEP  = 4,
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic                     in_stb,
  input  logic [W-1:0]             in_data,
  input  logic                     clr,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     seq_err,
  output logic [ERRW-1:0]          err_cnt,
  output logic                     ovf,
  output logic                     locked
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {UNSYNC, LOCKED} state_t;

  state_t       state, state_next;
  logic [W-1:0] expected, expected_next;
  logic         seq_err_next;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + ERRW'(1);
  endfunction

  // Checker: every accepted strobe resyncs expected to the received value + STEP
  always_comb begin
    state_next    = state;
    expected_next = expected;
    seq_err_next  = 1'b0;
    if (clr) begin
      state_next = UNSYNC;
    end else if (in_stb) begin
      expected_next = in_data + W'(STEP);
      state_next    = LOCKED;
      if (state == LOCKED && in_data != expected) seq_err_next = 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNSYNC;
      expected <= '0;
      seq_err  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_next;
      expected <= expected_next;
      seq_err  <= seq_err_next;
      if (clr)               err_cnt <= '0;
      else if (seq_err_next) err_cnt <= sat_inc(err_cnt);
    end
  end

  assign locked = (state == LOCKED);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   remain;
  logic          full, push, pop;
  logic [W-1:0]  head_next;

  assign out_valid = (occ != '0);
  assign full      = (occ == (AW+1)'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = in_stb && (!full || pop);
  assign rd_next   = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign remain    = occ - (AW+1)'(pop);
  // When the only entry left after this cycle is the one being written, bypass the array
  assign head_next = (remain == '0) ? in_data : mem[rd_next];

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      occ    <= occ + (AW+1)'(push) - (AW+1)'(pop);
      if (in_stb && !push) ovf <= 1'b1;
      if (remain != '0 || push) out_data <= head_next;
    end
  end

endmodule

// File: tb/tb_strobe_seq_rx.sv
// Testbench for strobe_seq_rx: directed scenarios plus randomized traffic against a queue-based model.
module tb_strobe_seq_rx;
  localparam int W = 16, STEP = 4, DEPTH = 4, ERRW = 8;

  logic          ck = 1'b0;
  logic          rst_n, in_stb, clr, out_ready;
  logic [W-1:0]  in_data;
  logic          out_valid, seq_err, ovf, locked;
  logic [W-1:0]  out_data;
  logic [2:0]    occ;
  logic [ERRW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  strobe_seq_rx #(.W(W), .STEP(STEP), .DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .ck(ck), .rst_n(rst_n), .in_stb(in_stb), .in_data(in_data), .clr(clr),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .occ(occ),
    .seq_err(seq_err), .err_cnt(err_cnt), .ovf(ovf), .locked(locked)
  );

  always #5 ck = ~ck;

  // Reference model state
  logic [W-1:0] m_q[$];
  bit           m_locked, m_ovf, m_seq;
  logic [W-1:0] m_exp, m_out;
  int           m_err;

  task automatic model_reset();
    m_q.delete();
    m_locked = 0; m_ovf = 0; m_seq = 0; m_exp = '0; m_out = '0; m_err = 0;
  endtask

  // Drive one cycle of inputs, advance the model, sample outputs 1 time unit after the edge
  task automatic step(input bit stb, input logic [W-1:0] d, input bit rdy, input bit c);
    bit pop, full;
    in_stb = stb; in_data = d; out_ready = rdy; clr = c;
    if (c) begin
      m_seq = 0; m_q.delete(); m_ovf = 0; m_err = 0; m_locked = 0;
    end else begin
      pop  = (m_q.size() > 0) && rdy;
      full = (m_q.size() == DEPTH);
      m_seq = 0;
      if (stb) begin
        if (m_locked && d != m_exp) begin
          m_seq = 1;
          if (m_err < 255) m_err++;
        end
        m_exp = d + 16'(STEP);
        m_locked = 1;
      end
      if (pop) void'(m_q.pop_front());
      if (stb) begin
        if (!full || pop) m_q.push_back(d);
        else m_ovf = 1;
      end
      if (m_q.size() > 0) m_out = m_q[0];
    end
    @(posedge ck); #1;
    in_stb = 0; clr = 0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err got %0b want 0", seq_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
  endtask

  task automatic test_stream();
    logic [W-1:0] v;
    for (int k = 0; k < 4; k++) begin
      v = 16'(k * 4);
      step(1, v, 1, 0);
      checks++; if (out_valid !== 1'b1 || out_data !== v) begin errors++; $display("FAIL t1_head got valid=%0b data=%0h want valid=1 data=%0h", out_valid, out_data, v); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL t1_locked got %0b want 1", locked); end
      for (int j = 0; j < 3; j++) begin
        step(0, 16'h0, 1, 0);
        checks++; if (seq_err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t1_idle got seq_err=%0b valid=%0b want 0 0", seq_err, out_valid); end
      end
    end
  endtask

  task automatic test_seq_err();
    step(1, 16'h0010, 1, 0);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL t2_good got seq_err=%0b want 0", seq_err); end
    step(1, 16'h0018, 1, 0);
    checks++; if (seq_err !== 1'b1 || err_cnt !== 8'd1) begin errors++; $display("FAIL t2_bad got seq_err=%0b err_cnt=%0d want 1 1", seq_err, err_cnt); end
    step(0, 16'h0, 1, 0);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL t2_pulse_width got seq_err=%0b want 0", seq_err); end
    step(1, 16'h001C, 1, 0);
    checks++; if (seq_err !== 1'b0 || err_cnt !== 8'd1) begin errors++; $display("FAIL t2_resync got seq_err=%0b err_cnt=%0d want 0 1", seq_err, err_cnt); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] v;
    step(0, 16'h0, 0, 1);
    for (int k = 0; k < 5; k++) step(1, 16'(k * 4), 0, 0);
    checks++; if (occ !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL t3_full got occ=%0d ovf=%0b want 4 1", occ, ovf); end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0) begin errors++; $display("FAIL t3_head got valid=%0b data=%0h want 1 0", out_valid, out_data); end
    for (int k = 0; k < 4; k++) begin
      v = 16'(k * 4);
      checks++; if (out_valid !== 1'b1 || out_data !== v) begin errors++; $display("FAIL t3_drain got valid=%0b data=%0h want 1 %0h", out_valid, out_data, v); end
      step(0, 16'h0, 1, 0);
    end
    checks++; if (out_valid !== 1'b0 || occ !== 3'd0 || out_data !== 16'hC) begin errors++; $display("FAIL t3_empty got valid=%0b occ=%0d data=%0h want 0 0 c", out_valid, occ, out_data); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL t3_ovf_sticky got %0b want 1", ovf); end
  endtask

  task automatic test_full_pushpop();
    step(0, 16'h0, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 16'(k * 4), 0, 0);
    checks++; if (occ !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL t4_fill got occ=%0d ovf=%0b want 4 0", occ, ovf); end
    step(1, 16'h0010, 1, 0);
    checks++; if (occ !== 3'd4 || ovf !== 1'b0 || out_data !== 16'h4) begin errors++; $display("FAIL t4_pushpop got occ=%0d ovf=%0b data=%0h want 4 0 4", occ, ovf, out_data); end
    for (int k = 2; k < 5; k++) begin
      step(0, 16'h0, 1, 0);
      checks++; if (out_data !== 16'(k * 4)) begin errors++; $display("FAIL t4_order got %0h want %0h", out_data, 16'(k * 4)); end
    end
    step(0, 16'h0, 1, 0);
  endtask

  task automatic test_wrap_saturate();
    logic [W-1:0] seq [3];
    seq[0] = 16'hFFF8; seq[1] = 16'hFFFC; seq[2] = 16'h0000;
    step(0, 16'h0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, seq[k], 1, 0);
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL t5_wrap got seq_err=%0b want 0 at %0h", seq_err, seq[k]); end
    end
    for (int i = 0; i < 260; i++) begin
      step(1, m_exp + 16'd1, 1, 0);
      checks++; if (seq_err !== 1'b1 || err_cnt !== 8'(m_err)) begin errors++; $display("FAIL t5_count got seq_err=%0b err_cnt=%0d want 1 %0d", seq_err, err_cnt, m_err); end
    end
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL t5_saturate got %0h want ff", err_cnt); end
  endtask

  task automatic test_clr();
    step(0, 16'h0, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 16'(k * 4), 0, 0);
    step(1, 16'h0050, 0, 0);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 0);
    step(1, 16'h0077, 0, 0);
    checks++; if (occ !== 3'd3 || ovf !== 1'b1 || err_cnt !== 8'd2 || seq_err !== 1'b1) begin errors++; $display("FAIL t6_pre got occ=%0d ovf=%0b err=%0d seq_err=%0b want 3 1 2 1", occ, ovf, err_cnt, seq_err); end
    step(1, 16'h0123, 0, 1);
    checks++; if (occ !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL t6_flush got occ=%0d valid=%0b want 0 0", occ, out_valid); end
    checks++; if (ovf !== 1'b0 || err_cnt !== 8'd0 || locked !== 1'b0 || seq_err !== 1'b0) begin errors++; $display("FAIL t6_clear got ovf=%0b err=%0d locked=%0b seq_err=%0b want 0 0 0 0", ovf, err_cnt, locked, seq_err); end
    step(1, 16'h0200, 1, 0);
    checks++; if (out_data !== 16'h0200 || locked !== 1'b1 || seq_err !== 1'b0) begin errors++; $display("FAIL t6_relock got data=%0h locked=%0b seq_err=%0b want 200 1 0", out_data, locked, seq_err); end
    step(1, 16'h0204, 0, 0);
    step(1, 16'h0300, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occ !== 3'd0 || out_data !== 16'h0) begin errors++; $display("FAIL t6_rst_fifo got valid=%0b occ=%0d data=%0h want 0 0 0", out_valid, occ, out_data); end
    checks++; if (seq_err !== 1'b0 || err_cnt !== 8'd0 || ovf !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL t6_rst_ctrl got seq_err=%0b err=%0d ovf=%0b locked=%0b want 0 0 0 0", seq_err, err_cnt, ovf, locked); end
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge ck); #1;
    step(1, 16'h0555, 1, 0);
    checks++; if (seq_err !== 1'b0 || locked !== 1'b1 || out_data !== 16'h0555) begin errors++; $display("FAIL t6_post_rst got seq_err=%0b locked=%0b data=%0h want 0 1 555", seq_err, locked, out_data); end
    step(1, 16'h0560, 1, 0);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL t6_post_rst_err got %0b want 1", seq_err); end
  endtask

  task automatic test_random();
    bit stb, c, rdy;
    logic [W-1:0] d;
    for (int i = 0; i < 800; i++) begin
      stb = ($urandom_range(0, 2) != 0);
      c   = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      d   = ($urandom_range(0, 4) == 0) ? 16'($urandom) : m_exp;
      step(stb, d, rdy, c);
      checks++; if (out_valid !== (m_q.size() > 0) || occ !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_occ cyc %0d got valid=%0b occ=%0d want %0d", i, out_valid, occ, m_q.size()); end
      checks++; if (out_data !== m_out) begin errors++; $display("FAIL rnd_data cyc %0d got %0h want %0h", i, out_data, m_out); end
      checks++; if (seq_err !== m_seq || err_cnt !== 8'(m_err)) begin errors++; $display("FAIL rnd_err cyc %0d got seq_err=%0b err=%0d want %0b %0d", i, seq_err, err_cnt, m_seq, m_err); end
      checks++; if (ovf !== m_ovf || locked !== m_locked) begin errors++; $display("FAIL rnd_flags cyc %0d got ovf=%0b locked=%0b want %0b %0b", i, ovf, locked, m_ovf, m_locked); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_stb = 1'b0; in_data = '0; clr = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge ck); @(posedge ck); #1;
    test_reset();
    rst_n = 1'b1;
    test_stream();
    test_seq_err();
    test_overflow();
    test_full_pushpop();
    test_wrap_saturate();
    test_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
